// File: rtl/car_pkg.sv
// Shared definitions for the car controller slice: controller state
// encodings, display width and BCD helpers used by the mileage meter.
package car_pkg;

    // Controller state encodings, as driven by the car controller FSM.
    typedef enum logic [3:0] {
        CAR_POWER_OFF    = 4'b0000,
        CAR_POWER_ON     = 4'b0001,
        CAR_NOT_STARTING = 4'b0010,
        CAR_STARTING     = 4'b0011,
        CAR_MOVING       = 4'b0100
    } car_state_e;

    // Number of BCD decades shown on the seven-segment display.
    localparam int DIGITS_DISPLAY = 8;

    // Largest legal value of one BCD decade.
    localparam logic [3:0] BCD_MAX = 4'd9;

    // Next value of one BCD decade; anything at or above 9 folds back to 0
    // so a decade can never leave the 0..9 range.
    function automatic logic [3:0] bcd_incr(input logic [3:0] d);
        logic [3:0] r;
        if (d >= BCD_MAX) begin
            r = 4'd0;
        end else begin
            r = d + 4'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of the odometer. Increments when its carry-in is high and
// passes a carry to the next decade when it rolls 9 -> 0.
module bcd_digit
    import car_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout
);

    logic [3:0] digit_r;

    // Decade register: async reset, synchronous clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_r <= 4'd0;
        end else if (clr) begin
            digit_r <= 4'd0;
        end else if (cin) begin
            digit_r <= bcd_incr(digit_r);
        end else begin
            digit_r <= digit_r;
        end
    end

    assign digit = digit_r;
    // Ripple carry: combinational, so every decade settles in the same cycle.
    assign cout  = cin & (digit_r == BCD_MAX);

endmodule

// File: rtl/mileage_meter.sv
// Mileage meter: counts clocks of active motion, turns every
// TICKS_PER_UNIT of them into one unit added to a packed-BCD odometer,
// and reports a unit pulse plus a sticky roll-over flag.
module mileage_meter
    import car_pkg::*;
#(
    parameter int TICKS_PER_UNIT = 100_000_000,
    parameter int DIGITS         = DIGITS_DISPLAY
) (
    input  logic                  sys_clk,
    input  logic                  rst,
    input  logic                  moving,
    input  logic                  move_forward,
    input  logic                  move_backward,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   mileage_bcd,
    output logic                  unit_pulse,
    output logic                  wrapped,
    output logic                  active
);

    localparam int              PRE_W    = $clog2(TICKS_PER_UNIT);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_UNIT - 1);

    logic [PRE_W-1:0] prescaler_r;
    logic             active_s;
    logic             inc_s;
    logic [DIGITS:0]  carry_s;
    logic             unit_pulse_r;
    logic             wrapped_r;

    // Motion qualification and unit request. Direction is irrelevant;
    // conflicting or absent commands mean standstill. Reset also forces
    // standstill since the prescaler cannot count then.
    always_comb begin
        active_s = rst & moving & (move_forward ^ move_backward);
        inc_s    = 1'b0;
        if (active_s && (prescaler_r == PRE_LAST)) begin
            inc_s = 1'b1;
        end else begin
            inc_s = 1'b0;
        end
    end

    // Prescaler: counts active clocks, holds across stops so partial units
    // are kept, and restarts at zero on each completed unit or a clear.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            prescaler_r <= '0;
        end else if (clear) begin
            prescaler_r <= '0;
        end else if (inc_s) begin
            prescaler_r <= '0;
        end else if (active_s) begin
            prescaler_r <= prescaler_r + PRE_W'(1);
        end else begin
            prescaler_r <= prescaler_r;
        end
    end

    assign carry_s[0] = inc_s;

    // One decade per BCD digit; the carry chain ripples through them.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clk   (sys_clk),
            .rst   (rst),
            .clr   (clear),
            .cin   (carry_s[g]),
            .digit (mileage_bcd[4*g +: 4]),
            .cout  (carry_s[g+1])
        );
    end

    // Unit pulse aligned with the updated odometer value; clear suppresses it.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            unit_pulse_r <= 1'b0;
        end else if (clear) begin
            unit_pulse_r <= 1'b0;
        end else begin
            unit_pulse_r <= inc_s;
        end
    end

    // Sticky roll-over flag, set when the carry leaves the top decade.
    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            wrapped_r <= 1'b0;
        end else if (clear) begin
            wrapped_r <= 1'b0;
        end else begin
            wrapped_r <= wrapped_r | carry_s[DIGITS];
        end
    end

    assign unit_pulse = unit_pulse_r;
    assign wrapped    = wrapped_r;
    assign active     = active_s;

endmodule

// File: tb/tb_mileage_meter.sv
// Bench for mileage_meter: a 10-tick/8-digit instance and a 2-tick/2-digit
// instance share the same stimulus and are both compared against a
// unit-counting reference model, plus directed checks with fixed values.
module tb_mileage_meter;

    logic        sys_clk = 1'b0;
    logic        rst     = 1'b0;
    logic        moving  = 1'b1;
    logic        fwd     = 1'b1;
    logic        bwd     = 1'b0;
    logic        clear   = 1'b0;

    logic [31:0] bcd_a;
    logic [7:0]  bcd_b;
    logic        pulse_a, pulse_b, wr_a, wr_b, act_a, act_b;

    int n_cmp  = 0;
    int n_fail = 0;

    // reference model state: whole units driven, ticks toward next unit
    int m_ticks [2];
    int m_units [2];
    int m_pulse [2];
    int m_wr    [2];
    int tpu     [2] = '{10, 2};
    int lim     [2] = '{100000000, 100};

    always #5 sys_clk = ~sys_clk;

    mileage_meter #(.TICKS_PER_UNIT(10), .DIGITS(8)) dut_a (
        .sys_clk(sys_clk), .rst(rst), .moving(moving),
        .move_forward(fwd), .move_backward(bwd), .clear(clear),
        .mileage_bcd(bcd_a), .unit_pulse(pulse_a), .wrapped(wr_a),
        .active(act_a)
    );

    mileage_meter #(.TICKS_PER_UNIT(2), .DIGITS(2)) dut_b (
        .sys_clk(sys_clk), .rst(rst), .moving(moving),
        .move_forward(fwd), .move_backward(bwd), .clear(clear),
        .mileage_bcd(bcd_b), .unit_pulse(pulse_b), .wrapped(wr_b),
        .active(act_b)
    );

    function automatic logic [31:0] to_bcd(input int unsigned val);
        logic [31:0]  r;
        int unsigned  v;
        r = 32'h0;
        v = val;
        for (int k = 0; k < 8; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_ticks[i] = 0; m_units[i] = 0; m_pulse[i] = 0; m_wr[i] = 0;
        end
    endtask

    task automatic model_edge(input logic mv, input logic fw, input logic bw, input logic cl);
        for (int i = 0; i < 2; i++) begin
            if (cl) begin
                m_ticks[i] = 0; m_units[i] = 0; m_pulse[i] = 0; m_wr[i] = 0;
            end else begin
                m_pulse[i] = 0;
                if (mv && (fw != bw)) begin
                    m_ticks[i]++;
                    if (m_ticks[i] == tpu[i]) begin
                        m_ticks[i] = 0;
                        m_units[i]++;
                        m_pulse[i] = 1;
                        if (m_units[i] == lim[i]) begin
                            m_units[i] = 0;
                            m_wr[i]    = 1;
                        end
                    end
                end
            end
        end
    endtask

    task automatic check_model();
        chk("bcd_a",   bcd_a,           to_bcd(m_units[0]));
        chk("pulse_a", 32'(pulse_a),    32'(m_pulse[0]));
        chk("wrap_a",  32'(wr_a),       32'(m_wr[0]));
        chk("bcd_b",   32'(bcd_b),      to_bcd(m_units[1]));
        chk("pulse_b", 32'(pulse_b),    32'(m_pulse[1]));
        chk("wrap_b",  32'(wr_b),       32'(m_wr[1]));
    endtask

    // one clock: drive on falling edge, check active, then check after rise
    task automatic cyc(input logic mv, input logic fw, input logic bw, input logic cl);
        logic exp_act;
        @(negedge sys_clk);
        moving = mv; fwd = fw; bwd = bw; clear = cl;
        #1;
        exp_act = mv & (fw ^ bw);
        chk("active_a", 32'(act_a), 32'(exp_act));
        chk("active_b", 32'(act_b), 32'(exp_act));
        @(posedge sys_clk);
        model_edge(mv, fw, bw, cl);
        #1;
        check_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        model_reset();

        // reset held with motion commanded
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_bcd",    bcd_a,          32'h0);
        chk("rst_pulse",  32'(pulse_a),   32'h0);
        chk("rst_wrap",   32'(wr_a),      32'h0);
        chk("rst_active", 32'(act_a),     32'h0);

        // release just after an edge; first unit after exactly 10 clocks
        @(posedge sys_clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0);
            chk("first_early", 32'(pulse_a), 32'h0);
        end
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("first_pulse", 32'(pulse_a), 32'h1);
        chk("first_bcd",   bcd_a,        32'h1);

        // pause keeps the partial unit; both directions high is no motion
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        run(6);
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5;  i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 5;  i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
        chk("pause_bcd", bcd_a, 32'h0);
        run(3);
        chk("pause_early", 32'(pulse_a), 32'h0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("pause_pulse", 32'(pulse_a), 32'h1);
        chk("pause_bcd1",  bcd_a,        32'h1);

        // decade carries
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        run(90);
        chk("dec_9",  bcd_a, 32'h9);
        run(10);
        chk("dec_10", bcd_a, 32'h10);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        run(990);
        chk("dec_99",  bcd_a, 32'h99);
        run(10);
        chk("dec_100", bcd_a, 32'h100);

        // roll-over from all nines on the small instance
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        run(198);
        chk("wrap_pre_bcd",  32'(bcd_b), 32'h99);
        chk("wrap_pre_flag", 32'(wr_b),  32'h0);
        run(2);
        chk("wrap_bcd",   32'(bcd_b),   32'h0);
        chk("wrap_flag",  32'(wr_b),    32'h1);
        chk("wrap_pulse", 32'(pulse_b), 32'h1);
        run(10);
        chk("wrap_sticky", 32'(wr_b), 32'h1);

        // clear in the same cycle the prescaler completes a unit
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        run(9);
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        chk("clrpri_bcd",   bcd_a,          32'h0);
        chk("clrpri_pulse", 32'(pulse_a),   32'h0);
        chk("clrpri_wrap",  32'(wr_b),      32'h0);
        run(9);
        chk("clrpri_early", 32'(pulse_a), 32'h0);
        run(1);
        chk("clrpri_pulse2", 32'(pulse_a), 32'h1);
        chk("clrpri_bcd2",   bcd_a,        32'h1);

        // async reset between edges with the prescaler at 7
        cyc(1'b1, 1'b1, 1'b0, 1'b1);
        run(127);
        chk("arst_pre_bcd", bcd_a, 32'h12);
        @(negedge sys_clk);
        #2 rst = 1'b0;
        #1;
        chk("arst_bcd",    bcd_a,        32'h0);
        chk("arst_bcd_b",  32'(bcd_b),   32'h0);
        chk("arst_pulse",  32'(pulse_a), 32'h0);
        chk("arst_active", 32'(act_a),   32'h0);
        model_reset();
        repeat (2) @(posedge sys_clk);
        #2 rst = 1'b1;
        run(9);
        chk("arst_early", 32'(pulse_a), 32'h0);
        run(1);
        chk("arst_pulse2", 32'(pulse_a), 32'h1);
        chk("arst_bcd2",   bcd_a,        32'h1);

        // randomized motion commands with occasional clears
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)),
                ($urandom_range(0, 63) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
